// File: rtl/uart_baud_gen.sv
// Fractional-N UART tick generator: s_tick every int or int+1 cycles (mean int+frac/2^FRAC_W), b_tick every SAMPLE s_ticks.
// Ticks decode registered phase in the same cycle (no added latency); no backpressure, en=0 freezes phase.
module uart_baud_gen #(
  parameter int DVSR_W   = 16,
  parameter int FRAC_W   = 4,
  parameter int SAMPLE   = 16,
  parameter int DEF_INT  = 3,
  parameter int DEF_FRAC = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              restart,
  input  logic              dvsr_load,
  input  logic [DVSR_W-1:0] dvsr_int,
  input  logic [FRAC_W-1:0] dvsr_frac,
  output logic              s_tick,
  output logic              b_tick,
  output logic              load_pending
);

  localparam int SMP_W = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
  localparam logic [DVSR_W-1:0] RST_INT  = (DEF_INT == 0) ? DVSR_W'(1) : DVSR_W'(DEF_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEF_FRAC);
  localparam logic [SMP_W-1:0]  SMP_LAST = SMP_W'(SAMPLE - 1);

  logic [DVSR_W-1:0] int_q, int_d, sh_int_q, sh_int_d, cnt_q, cnt_d;
  logic [DVSR_W-1:0] new_int, last_cnt;
  logic [FRAC_W-1:0] frac_q, frac_d, sh_frac_q, sh_frac_d, acc_q, acc_d;
  logic              ext_q, ext_d, pend_q, pend_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic              boundary, apply;

  always_comb begin
    new_int   = (dvsr_int == '0) ? DVSR_W'(1) : dvsr_int;
    last_cnt  = int_q - DVSR_W'(1) + DVSR_W'(ext_q);
    boundary  = en && !restart && (cnt_q == last_cnt);
    apply     = boundary || restart || !en;

    int_d     = int_q;
    frac_d    = frac_q;
    sh_int_d  = sh_int_q;
    sh_frac_d = sh_frac_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ext_d     = ext_q;
    smp_d     = smp_q;

    if (dvsr_load) begin
      sh_int_d  = new_int;
      sh_frac_d = dvsr_frac;
      pend_d    = 1'b1;
    end
    // With nothing pending the shadow mirrors the active divisor, so applying is always safe.
    if (apply) begin
      int_d  = sh_int_d;
      frac_d = sh_frac_d;
      pend_d = 1'b0;
    end

    if (restart) begin
      cnt_d = '0;
      acc_d = '0;
      ext_d = 1'b0;
      smp_d = '0;
    end else if (boundary) begin
      cnt_d          = '0;
      // The carry lengthens the period starting now, so it uses the divisor applied now.
      {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_d};
      smp_d          = (smp_q == SMP_LAST) ? '0 : smp_q + SMP_W'(1);
    end else if (en) begin
      cnt_d = cnt_q + DVSR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_q     <= RST_INT;
      frac_q    <= RST_FRAC;
      sh_int_q  <= RST_INT;
      sh_frac_q <= RST_FRAC;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      ext_q     <= 1'b0;
      smp_q     <= '0;
    end else begin
      int_q     <= int_d;
      frac_q    <= frac_d;
      sh_int_q  <= sh_int_d;
      sh_frac_q <= sh_frac_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ext_q     <= ext_d;
      smp_q     <= smp_d;
    end
  end

  assign s_tick       = boundary;
  assign b_tick       = boundary && (smp_q == SMP_LAST);
  assign load_pending = pend_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed scenarios plus random traffic against a period-length reference model.
module tb_uart_baud_gen;

  localparam int DVSR_W = 16;
  localparam int FRAC_W = 4;
  localparam int SAMPLE = 16;
  localparam int FR     = 1 << FRAC_W;

  logic              clk = 1'b0;
  logic              reset_n, en, restart, dvsr_load;
  logic [DVSR_W-1:0] dvsr_int;
  logic [FRAC_W-1:0] dvsr_frac;
  logic              s_tick, b_tick, load_pending;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: active/shadow divisor, enabled cycles elapsed in the current
  // period, extra cycle owed to this period, fractional phase and tick count.
  int m_int, m_frac, m_sh_int, m_sh_frac, m_elapsed, m_carry, m_phase, m_nticks;
  bit m_pend, exp_s, exp_b, exp_p;

  always #5 clk = ~clk;

  uart_baud_gen #(
    .DVSR_W(DVSR_W), .FRAC_W(FRAC_W), .SAMPLE(SAMPLE), .DEF_INT(3), .DEF_FRAC(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .restart(restart),
    .dvsr_load(dvsr_load), .dvsr_int(dvsr_int), .dvsr_frac(dvsr_frac),
    .s_tick(s_tick), .b_tick(b_tick), .load_pending(load_pending)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
    $fatal(1);
  end

  function automatic void model_reset();
    m_int = 3; m_frac = 6; m_sh_int = 3; m_sh_frac = 6; m_pend = 0;
    m_elapsed = 0; m_carry = 0; m_phase = 0; m_nticks = 0;
  endfunction

  // One clock cycle: present inputs, compute expected outputs, advance the model.
  task automatic drive(input bit e, input bit r, input bit l, input int di, input int df);
    int sum;
    @(negedge clk);
    en = e; restart = r; dvsr_load = l;
    dvsr_int = DVSR_W'(di); dvsr_frac = FRAC_W'(df);
    #1;
    exp_s = e && !r && (m_elapsed + 1 == m_int + m_carry);
    exp_b = exp_s && (m_nticks % SAMPLE == SAMPLE - 1);
    exp_p = m_pend;
    if (l) begin
      m_sh_int = (di == 0) ? 1 : di; m_sh_frac = df; m_pend = 1;
    end
    if (exp_s || r || !e) begin
      m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0;
    end
    if (r) begin
      m_elapsed = 0; m_carry = 0; m_phase = 0; m_nticks = 0;
    end else if (exp_s) begin
      sum = m_phase + m_frac;
      m_carry = sum / FR; m_phase = sum % FR; m_elapsed = 0; m_nticks++;
    end else if (e) begin
      m_elapsed++;
    end
    cyc++;
  endtask

  // Runs enabled cycles until the DUT ticks; ncyc is the tick's 1-based cycle index or -1.
  task automatic run_to_tick(input string tag, input int budget, output int ncyc);
    ncyc = -1;
    for (int i = 1; i <= budget; i++) begin
      drive(1, 0, 0, 0, 0);
      n_checks++;
      if ({s_tick, b_tick, load_pending} !== {exp_s, exp_b, exp_p})
        $display("FAIL %s cyc=%0d s/b/pend got %b%b%b exp %b%b%b", tag, cyc,
                 s_tick, b_tick, load_pending, exp_s, exp_b, exp_p);
      else n_pass++;
      if (s_tick === 1'b1) begin
        ncyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 0; en = 0; restart = 0; dvsr_load = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({s_tick, b_tick, load_pending} !== 3'b000)
      $display("FAIL reset_outputs got %b%b%b exp 000", s_tick, b_tick, load_pending);
    else n_pass++;
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_default();
    int nt = 0, nb = 0, t8 = -1, t16 = -1, first_b = -1;
    for (int i = 0; i < 160; i++) begin
      drive(1, 0, 0, 0, 0);
      n_checks++;
      if ({s_tick, b_tick, load_pending} !== {exp_s, exp_b, exp_p})
        $display("FAIL default cyc=%0d s/b/pend got %b%b%b exp %b%b%b", cyc,
                 s_tick, b_tick, load_pending, exp_s, exp_b, exp_p);
      else n_pass++;
      if (s_tick === 1'b1) begin
        nt++;
        if (nt == 8) t8 = i;
        if (nt == 16) t16 = i;
      end
      if (b_tick === 1'b1) begin
        nb++;
        if (first_b < 0) first_b = i;
      end
    end
    n_checks++;
    if (t16 != 52) $display("FAIL default_16th_tick got cycle %0d exp 52", t16); else n_pass++;
    n_checks++;
    if (t16 - t8 != 27) $display("FAIL default_8_tick_span got %0d exp 27", t16 - t8); else n_pass++;
    n_checks++;
    if (first_b != 52) $display("FAIL default_first_b_tick got cycle %0d exp 52", first_b); else n_pass++;
    n_checks++;
    if (nt != 47 || nb != 2) $display("FAIL default_counts got %0d/%0d exp 47/2", nt, nb); else n_pass++;
  endtask

  task automatic test_load_midperiod();
    int n;
    run_to_tick("lm_sync", 20, n);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 10, 0);
    n_checks++;
    if ({s_tick, load_pending} !== {exp_s, exp_p})
      $display("FAIL lm_load_cycle got %b%b exp %b%b", s_tick, load_pending, exp_s, exp_p);
    else n_pass++;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      drive(1, 0, 0, 0, 0);
      n_checks++;
      if ({s_tick, b_tick, load_pending} !== {exp_s, exp_b, exp_p})
        $display("FAIL lm_old cyc=%0d s/b/pend got %b%b%b exp %b%b%b", cyc,
                 s_tick, b_tick, load_pending, exp_s, exp_b, exp_p);
      else n_pass++;
      n_checks++;
      if (load_pending !== 1'b1) $display("FAIL lm_pending_held got %b exp 1", load_pending);
      else n_pass++;
      if (s_tick === 1'b1) begin
        n = i;
        break;
      end
    end
    n_checks++;
    if (n < 1 || n > 2) $display("FAIL lm_old_period_end got %0d exp 1..2", n); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      run_to_tick("lm_new", 20, n);
      n_checks++;
      if (n != 10) $display("FAIL lm_new_period got %0d exp 10", n); else n_pass++;
    end
    n_checks++;
    if (load_pending !== 1'b0) $display("FAIL lm_pending_cleared got %b exp 0", load_pending);
    else n_pass++;
  endtask

  task automatic test_en_hold();
    int n;
    run_to_tick("eh_sync", 20, n);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if ({s_tick, b_tick, load_pending} !== {exp_s, exp_b, exp_p} || {s_tick, b_tick} !== 2'b00)
        $display("FAIL en_hold cyc=%0d s/b/pend got %b%b%b exp %b%b%b", cyc,
                 s_tick, b_tick, load_pending, exp_s, exp_b, exp_p);
      else n_pass++;
    end
    run_to_tick("eh_resume", 20, n);
    n_checks++;
    if (n != 9) $display("FAIL en_resume_tick got %0d exp 9", n); else n_pass++;
  endtask

  task automatic test_restart();
    int n, nt = 0, first_t = -1, b_at = -1;
    drive(1, 0, 1, 5, 3);
    run_to_tick("rs_apply", 20, n);
    for (int i = 0; i < 20; i++) begin
      if (m_elapsed + 2 == m_int + m_carry) break;
      drive(1, 0, 0, 0, 0);
    end
    drive(1, 1, 0, 0, 0);
    n_checks++;
    if ({s_tick, b_tick} !== 2'b00 || exp_s !== 1'b0)
      $display("FAIL restart_no_tick got %b%b exp 00", s_tick, b_tick);
    else n_pass++;
    for (int i = 1; i <= 200 && b_at < 0; i++) begin
      drive(1, 0, 0, 0, 0);
      n_checks++;
      if ({s_tick, b_tick, load_pending} !== {exp_s, exp_b, exp_p})
        $display("FAIL restart_run cyc=%0d s/b/pend got %b%b%b exp %b%b%b", cyc,
                 s_tick, b_tick, load_pending, exp_s, exp_b, exp_p);
      else n_pass++;
      if (s_tick === 1'b1) begin
        nt++;
        if (first_t < 0) first_t = i;
      end
      if (b_tick === 1'b1) b_at = nt;
    end
    n_checks++;
    if (first_t != 5) $display("FAIL restart_first_tick got %0d exp 5", first_t); else n_pass++;
    n_checks++;
    if (b_at != 16) $display("FAIL restart_b_tick_index got %0d exp 16", b_at); else n_pass++;
  endtask

  task automatic test_zero_div();
    int nt = 0, nb = 0, first_b = -1, last_b = -1;
    drive(1, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 0);
      n_checks++;
      if ({s_tick, b_tick, load_pending} !== {exp_s, exp_b, exp_p})
        $display("FAIL zero_div cyc=%0d s/b/pend got %b%b%b exp %b%b%b", cyc,
                 s_tick, b_tick, load_pending, exp_s, exp_b, exp_p);
      else n_pass++;
      if (s_tick === 1'b1) nt++;
      if (b_tick === 1'b1) begin
        nb++;
        if (first_b < 0) first_b = i;
        last_b = i;
      end
    end
    n_checks++;
    if (nt != 32) $display("FAIL zero_div_ticks got %0d exp 32", nt); else n_pass++;
    n_checks++;
    if (nb != 2 || first_b != 15 || last_b != 31)
      $display("FAIL zero_div_b_ticks got n=%0d at %0d,%0d exp n=2 at 15,31", nb, first_b, last_b);
    else n_pass++;
  endtask

  task automatic test_load_at_boundary();
    int n;
    drive(1, 1, 1, 4, 0);
    drive(1, 0, 0, 0, 0);
    n_checks++;
    if (load_pending !== 1'b0) $display("FAIL restart_load_pending got %b exp 0", load_pending);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (m_elapsed + 1 == m_int + m_carry) break;
      drive(1, 0, 0, 0, 0);
    end
    drive(1, 0, 1, 7, 0);
    n_checks++;
    if (s_tick !== 1'b1) $display("FAIL boundary_load_tick got %b exp 1", s_tick); else n_pass++;
    run_to_tick("lb_new", 20, n);
    n_checks++;
    if (n != 7) $display("FAIL boundary_load_period got %0d exp 7", n); else n_pass++;
    n_checks++;
    if (load_pending !== 1'b0) $display("FAIL boundary_load_pending got %b exp 0", load_pending);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(9) != 0, $urandom_range(49) == 0, $urandom_range(19) == 0,
            int'($urandom_range(6)), int'($urandom_range(15)));
      n_checks++;
      if ({s_tick, b_tick, load_pending} !== {exp_s, exp_b, exp_p})
        $display("FAIL random cyc=%0d s/b/pend got %b%b%b exp %b%b%b", cyc,
                 s_tick, b_tick, load_pending, exp_s, exp_b, exp_p);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    drive(1, 1, 1, 6, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 9, 5);
    drive(1, 0, 0, 0, 0);
    n_checks++;
    if (load_pending !== 1'b1) $display("FAIL reset_mid_pending_before got %b exp 1", load_pending);
    else n_pass++;
    test_reset();
    run_to_tick("rm_after", 10, n);
    n_checks++;
    if (n != 3) $display("FAIL reset_mid_first_tick got %0d exp 3", n); else n_pass++;
  endtask

  initial begin
    reset_n = 0; en = 0; restart = 0; dvsr_load = 0; dvsr_int = '0; dvsr_frac = '0;
    test_reset();
    test_default();
    test_load_midperiod();
    test_en_hold();
    test_restart();
    test_zero_div();
    test_load_at_boundary();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
